// File: rtl/car_l2_pkg.sv
// Shared definitions for the Carfield L2 bank crossbar: mapping-mode
// encoding, default geometry and the word-index to bank/row split helpers.
package car_l2_pkg;

  // Address MSB selects how a word index is spread across the banks.
  typedef enum logic {
    L2_INTERLEAVE = 1'b0,
    L2_CONTIGUOUS = 1'b1
  } l2_mode_e;

  localparam int unsigned L2_NUM_PORTS  = 2;
  localparam int unsigned L2_NUM_BANKS  = 4;
  localparam int unsigned L2_BANK_WORDS = 4096;
  localparam int unsigned L2_DATA_WIDTH = 64;
  localparam int unsigned L2_CNT_WIDTH  = 16;

  // Bank index for a word: low bits when interleaved, high bits when contiguous.
  function automatic logic [31:0] l2_bank_of(input l2_mode_e    mode,
                                             input logic [31:0] word,
                                             input int unsigned bank_bits,
                                             input int unsigned row_bits);
    if (mode == L2_INTERLEAVE) begin
      return word & ((32'd1 << bank_bits) - 32'd1);
    end
    return word >> row_bits;
  endfunction

  // Row inside the selected bank: the bits not consumed by the bank index.
  function automatic logic [31:0] l2_row_of(input l2_mode_e    mode,
                                            input logic [31:0] word,
                                            input int unsigned bank_bits,
                                            input int unsigned row_bits);
    if (mode == L2_INTERLEAVE) begin
      return word >> bank_bits;
    end
    return word & ((32'd1 << row_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/car_l2_rr_arb.sv
// Round-robin arbiter for one SRAM bank. The pointer names the port with
// highest priority; it advances past the winner and holds while idle.
module car_l2_rr_arb
  import car_l2_pkg::*;
#(
  parameter  int unsigned NumPorts = L2_NUM_PORTS,
  localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [PtrWidth-1:0] gnt_idx_o,
  output logic                busy_o
);

  logic [PtrWidth-1:0] ptr_q;
  logic [PtrWidth-1:0] cand;
  logic                found;

  // Scan ports starting at the pointer (wrapping) and grant the first requester.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NumPorts; k++) begin
      cand = PtrWidth'((32'(ptr_q) + 32'(k)) % NumPorts);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        gnt_idx_o    = cand;
      end
    end
    busy_o = found;
  end

  // Pointer moves one past the winner; it is left alone on idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (gnt_idx_o == PtrWidth'(NumPorts - 1)) ? '0 : gnt_idx_o + PtrWidth'(1);
    end
  end

endmodule

// File: rtl/car_l2_bank_xbar.sv
// Multi-port L2 bank crossbar. Each port picks one bank per cycle using the
// interleaved or contiguous mapping chosen by its address MSB, every bank
// arbitrates round-robin, and responses return exactly one cycle after grant.
//
// Handshake: a port request is accepted in the cycle where req_i and gnt_o
// are both high; until then the initiator keeps req/addr/we/be/wdata stable.
// rvalid_o pulses one cycle after each accepted request (read or write) and
// cannot be stalled.
module car_l2_bank_xbar
  import car_l2_pkg::*;
#(
  parameter  int unsigned NumPorts     = L2_NUM_PORTS,
  parameter  int unsigned NumBanks     = L2_NUM_BANKS,
  parameter  int unsigned BankWords    = L2_BANK_WORDS,
  parameter  int unsigned DataWidth    = L2_DATA_WIDTH,
  parameter  int unsigned CntWidth     = L2_CNT_WIDTH,
  localparam int unsigned BeWidth      = DataWidth / 8,
  localparam int unsigned RowWidth     = $clog2(BankWords),
  localparam int unsigned WordIdxWidth = $clog2(NumBanks * BankWords),
  localparam int unsigned OffWidth     = WordIdxWidth + $clog2(BeWidth) + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 gnt_o,
  input  logic [NumPorts-1:0][OffWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic [NumBanks-1:0]                 bank_req_o,
  output logic [NumBanks-1:0]                 bank_we_o,
  output logic [NumBanks-1:0][RowWidth-1:0]   bank_addr_o,
  output logic [NumBanks-1:0][BeWidth-1:0]    bank_be_o,
  output logic [NumBanks-1:0][DataWidth-1:0]  bank_wdata_o,
  input  logic [NumBanks-1:0][DataWidth-1:0]  bank_rdata_i,
  input  logic                                cnt_clr_i,
  output logic [NumPorts-1:0][CntWidth-1:0]   conflict_cnt_o
);

  localparam int unsigned ByteBits = $clog2(BeWidth);
  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [NumPorts-1:0][BankBits-1:0] port_bank;
  logic [NumPorts-1:0][RowWidth-1:0] port_row;
  logic [NumBanks-1:0][NumPorts-1:0] bank_port_req;
  logic [NumBanks-1:0][NumPorts-1:0] bank_port_gnt;
  logic [NumBanks-1:0][PtrWidth-1:0] bank_gnt_idx;
  logic [NumBanks-1:0]               bank_busy;

  logic [NumPorts-1:0]               rvalid_q;
  logic [NumPorts-1:0][BankBits-1:0] bank_sel_q;
  logic [NumPorts-1:0][CntWidth-1:0] cnt_q;

  // Split each port's byte offset into a target bank and a row in that bank.
  always_comb begin
    port_bank = '0;
    port_row  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_bank[p] = BankBits'(l2_bank_of(l2_mode_e'(addr_i[p][OffWidth-1]),
                                          32'(addr_i[p][OffWidth-2:ByteBits]),
                                          BankBits, RowWidth));
      port_row[p]  = RowWidth'(l2_row_of(l2_mode_e'(addr_i[p][OffWidth-1]),
                                         32'(addr_i[p][OffWidth-2:ByteBits]),
                                         BankBits, RowWidth));
    end
  end

  // Route every valid port request to the arbiter of the bank it addresses.
  always_comb begin
    bank_port_req = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_port_req[b][p] = req_i[p] && (port_bank[p] == BankBits'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank_arb
    car_l2_rr_arb #(
      .NumPorts (NumPorts)
    ) i_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (bank_port_req[b]),
      .gnt_o     (bank_port_gnt[b]),
      .gnt_idx_o (bank_gnt_idx[b]),
      .busy_o    (bank_busy[b])
    );
  end

  // A port is granted when the arbiter of its own bank picked it.
  always_comb begin
    gnt_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      gnt_o[p] = bank_port_gnt[port_bank[p]][p];
    end
  end

  // Drive each bank from its winning port; idle banks drive all zeros.
  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_busy[b]) begin
        bank_req_o[b]   = 1'b1;
        bank_we_o[b]    = we_i[bank_gnt_idx[b]];
        bank_addr_o[b]  = port_row[bank_gnt_idx[b]];
        bank_be_o[b]    = be_i[bank_gnt_idx[b]];
        bank_wdata_o[b] = wdata_i[bank_gnt_idx[b]];
      end
    end
  end

  // Remember which bank each granted port used so its read data can be returned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= '0;
      bank_sel_q <= '0;
    end else begin
      rvalid_q   <= gnt_o;
      bank_sel_q <= port_bank;
    end
  end

  // Return the selected bank's SRAM output alongside the response pulse.
  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (rvalid_q[p]) begin
        rdata_o[p] = bank_rdata_i[bank_sel_q[p]];
      end
    end
  end

  assign rvalid_o = rvalid_q;

  // Count stalled request cycles per port; clear wins, all-ones is sticky.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (cnt_clr_i) begin
          cnt_q[p] <= '0;
        end else if (req_i[p] && !gnt_o[p] && (cnt_q[p] != '1)) begin
          cnt_q[p] <= cnt_q[p] + CntWidth'(1);
        end
      end
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_car_l2_bank_xbar.sv
// Self-checking bench for car_l2_bank_xbar: directed scenarios followed by
// random traffic, all compared against a behavioural model of mapping,
// round-robin fairness, memory contents and conflict counting.
module tb_car_l2_bank_xbar;

  localparam int NP    = 2;
  localparam int NB    = 4;
  localparam int BW    = 4096;
  localparam int DW    = 64;
  localparam int CW    = 4;
  localparam int BEW   = DW / 8;
  localparam int ROWW  = $clog2(BW);
  localparam int WIDXW = $clog2(NB * BW);
  localparam int BYTEB = $clog2(BEW);
  localparam int OFFW  = WIDXW + BYTEB + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]                req_i, gnt_o, we_i, rvalid_o;
  logic [NP-1:0][OFFW-1:0]      addr_i;
  logic [NP-1:0][BEW-1:0]       be_i;
  logic [NP-1:0][DW-1:0]        wdata_i, rdata_o;
  logic [NB-1:0]                bank_req_o, bank_we_o;
  logic [NB-1:0][ROWW-1:0]      bank_addr_o;
  logic [NB-1:0][BEW-1:0]       bank_be_o;
  logic [NB-1:0][DW-1:0]        bank_wdata_o, bank_rdata_i;
  logic                         cnt_clr_i;
  logic [NP-1:0][CW-1:0]        conflict_cnt_o;

  car_l2_bank_xbar #(
    .NumPorts  (NP),
    .NumBanks  (NB),
    .BankWords (BW),
    .DataWidth (DW),
    .CntWidth  (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .bank_req_o     (bank_req_o),
    .bank_we_o      (bank_we_o),
    .bank_addr_o    (bank_addr_o),
    .bank_be_o      (bank_be_o),
    .bank_wdata_o   (bank_wdata_o),
    .bank_rdata_i   (bank_rdata_i),
    .cnt_clr_i      (cnt_clr_i),
    .conflict_cnt_o (conflict_cnt_o)
  );

  // ---------------- SRAM macros (environment) ----------------
  logic [DW-1:0] sram [NB][BW];

  initial begin
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < BW; r++) sram[b][r] = '0;
    end
    bank_rdata_i = '0;
  end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_req_o[b]) begin
        bank_rdata_i[b] <= sram[b][bank_addr_o[b]];
        if (bank_we_o[b]) begin
          for (int i = 0; i < BEW; i++) begin
            if (bank_be_o[b][i]) sram[b][bank_addr_o[b]][8*i +: 8] <= bank_wdata_o[b][8*i +: 8];
          end
        end
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];          // expected read data, in grant order
  logic [DW-1:0] ref_mem [int];     // flat (bank*BW + row) -> word
  int            m_ptr [NB];
  logic [CW-1:0] m_cnt [NP];
  logic [NP-1:0] m_rv, m_rd, m_gnt;

  // stimulus currently presented per port
  logic [NP-1:0]           s_req, s_we;
  logic [NP-1:0][OFFW-1:0] s_addr;
  logic [NP-1:0][BEW-1:0]  s_be;
  logic [NP-1:0][DW-1:0]   s_wdata;
  logic                    s_clr;

  // DUT values seen in the most recent step
  logic [NP-1:0]           cap_gnt, cap_rvalid;
  logic [NB-1:0]           cap_breq;
  logic [NB-1:0][ROWW-1:0] cap_baddr;
  logic [NP-1:0][DW-1:0]   cap_rdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : '0;
  endfunction

  // Mapping rules in plain arithmetic.
  function automatic void map_addr(input logic [OFFW-1:0] a, output int bank, output int row);
    logic [OFFW-1:0] t;
    int w;
    t = a;
    w = int'(t[OFFW-2:BYTEB]);
    if (t[OFFW-1] == 1'b0) begin
      bank = w % NB;
      row  = w / NB;
    end else begin
      bank = w / BW;
      row  = w % BW;
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int p = 0; p < NP; p++) m_cnt[p] = '0;
    m_rv = '0; m_rd = '0; m_gnt = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    s_req = '0; s_we = '0; s_addr = '0; s_be = '0; s_wdata = '0; s_clr = 1'b0;
  endtask

  task automatic set_port(input int p, input bit mode, input int word, input bit we,
                          input logic [BEW-1:0] be, input logic [DW-1:0] wd);
    logic [OFFW-1:0] a;
    a = '0;
    a[OFFW-1] = mode;
    a[OFFW-2:BYTEB] = (OFFW-1-BYTEB)'(word);
    a[BYTEB-1:0] = BYTEB'($urandom_range(BEW-1));
    s_req[p] = 1'b1; s_addr[p] = a; s_we[p] = we; s_be[p] = be; s_wdata[p] = wd;
  endtask

  task automatic drive();
    req_i = s_req; addr_i = s_addr; we_i = s_we; be_i = s_be; wdata_i = s_wdata;
    cnt_clr_i = s_clr;
  endtask

  // One clock cycle: drive, check against model, advance model at the edge.
  task automatic step();
    int mb [NP];
    int mr [NP];
    int gi [NB];
    int p, key;
    logic [NP-1:0] egnt;
    logic [DW-1:0] nv;
    egnt = '0;
    for (int q = 0; q < NP; q++) map_addr(s_addr[q], mb[q], mr[q]);
    for (int b = 0; b < NB; b++) begin
      gi[b] = -1;
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr[b] + k) % NP;
        if (gi[b] < 0 && s_req[p] && mb[p] == b) gi[b] = p;
      end
      if (gi[b] >= 0) egnt[gi[b]] = 1'b1;
    end
    drive();
    #1;
    check_eq("gnt", 64'(gnt_o), 64'(egnt));
    for (int b = 0; b < NB; b++) begin
      if (gi[b] >= 0) begin
        check_eq("bank_req", 64'(bank_req_o[b]), 64'd1);
        check_eq("bank_we", 64'(bank_we_o[b]), 64'(s_we[gi[b]]));
        check_eq("bank_addr", 64'(bank_addr_o[b]), 64'(mr[gi[b]]));
        check_eq("bank_be", 64'(bank_be_o[b]), 64'(s_be[gi[b]]));
        check_eq("bank_wdata", bank_wdata_o[b], s_wdata[gi[b]]);
      end else begin
        check_eq("bank_idle", {bank_req_o[b], bank_we_o[b], 62'(bank_addr_o[b]) | 62'(bank_be_o[b])}, 64'd0);
        check_eq("bank_idle_wdata", bank_wdata_o[b], 64'd0);
      end
    end
    for (int q = 0; q < NP; q++) begin
      check_eq("rvalid", 64'(rvalid_o[q]), 64'(m_rv[q]));
      if (m_rv[q] && m_rd[q]) begin
        if (exp_q.size() == 0) check_eq("exp_q_empty", 64'd1, 64'd0);
        else check_eq("rdata", rdata_o[q], exp_q.pop_front());
      end else if (!m_rv[q]) begin
        check_eq("rdata_idle", rdata_o[q], 64'd0);
      end
      check_eq("conflict_cnt", 64'(conflict_cnt_o[q]), 64'(m_cnt[q]));
    end
    cap_gnt = gnt_o; cap_breq = bank_req_o; cap_baddr = bank_addr_o;
    cap_rdata = rdata_o; cap_rvalid = rvalid_o;
    // advance the model
    for (int q = 0; q < NP; q++) begin
      m_rv[q] = egnt[q];
      m_rd[q] = egnt[q] && !s_we[q];
      if (egnt[q]) begin
        key = mb[q] * BW + mr[q];
        if (!s_we[q]) begin
          exp_q.push_back(mem_rd(key));
        end else begin
          nv = mem_rd(key);
          for (int i = 0; i < BEW; i++) if (s_be[q][i]) nv[8*i +: 8] = s_wdata[q][8*i +: 8];
          ref_mem[key] = nv;
        end
      end
      if (s_clr) m_cnt[q] = '0;
      else if (s_req[q] && !egnt[q] && m_cnt[q] != CNT_MAX) m_cnt[q] = m_cnt[q] + 1'b1;
    end
    for (int b = 0; b < NB; b++) if (gi[b] >= 0) m_ptr[b] = (gi[b] + 1) % NP;
    m_gnt = egnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_idle();
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
    check_eq("rst_rdata0", rdata_o[0], 64'd0);
    check_eq("rst_rdata1", rdata_o[1], 64'd0);
    check_eq("rst_cnt", 64'(conflict_cnt_o), 64'd0);
    check_eq("rst_gnt", 64'(gnt_o), 64'd0);
    check_eq("rst_bank_req", 64'(bank_req_o), 64'd0);
    rst_ni = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    set_idle();
    drive();
    @(negedge clk);
    do_reset();

    // interleaved writes to consecutive words land on consecutive banks, row 0
    for (int i = 0; i < 4; i++) begin
      set_idle();
      set_port(0, 1'b0, i, 1'b1, 8'hFF, 64'hA0 + 64'(i));
      step();
      check_eq("t1_breq", 64'(cap_breq), 64'(1 << i));
      check_eq("t1_row", 64'(cap_baddr[i]), 64'd0);
    end
    for (int i = 0; i < 5; i++) begin
      set_idle();
      if (i < 4) set_port(0, 1'b0, i, 1'b0, 8'h00, 64'd0);
      step();
      if (i > 0) begin
        check_eq("t1_rvalid", 64'(cap_rvalid[0]), 64'd1);
        check_eq("t1_rdata", cap_rdata[0], 64'hA0 + 64'(i - 1));
      end
    end

    // contiguous word 4096 aliases interleaved word 1 (bank 1, row 0)
    set_idle();
    set_port(0, 1'b1, 4096, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    step();
    check_eq("t2_cont_breq", 64'(cap_breq), 64'b0010);
    check_eq("t2_cont_row", 64'(cap_baddr[1]), 64'd0);
    set_idle();
    set_port(0, 1'b0, 1, 1'b0, 8'h00, 64'd0);
    step();
    check_eq("t2_int_breq", 64'(cap_breq), 64'b0010);
    set_idle();
    step();
    check_eq("t2_alias_rdata", cap_rdata[0], 64'h0123_4567_89AB_CDEF);

    // both ports hammer bank 0 from reset: strict alternation, 4 stalls each
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_port(0, 1'b0, 0, 1'b0, 8'h00, 64'd0);
      set_port(1, 1'b0, 4, 1'b0, 8'h00, 64'd0);
      step();
      check_eq("t3_alternate", 64'(cap_gnt), (i % 2 == 0) ? 64'b01 : 64'b10);
    end
    #1;
    check_eq("t3_cnt0", 64'(conflict_cnt_o[0]), 64'd4);
    check_eq("t3_cnt1", 64'(conflict_cnt_o[1]), 64'd4);

    // different banks in the same cycle: both granted, both answered
    set_idle();
    set_port(0, 1'b0, 2, 1'b0, 8'h00, 64'd0);
    set_port(1, 1'b0, 3, 1'b0, 8'h00, 64'd0);
    step();
    check_eq("t4_both_gnt", 64'(cap_gnt), 64'b11);
    set_idle();
    step();
    check_eq("t4_rvalid", 64'(cap_rvalid), 64'b11);
    check_eq("t4_rdata0", cap_rdata[0], 64'hA2);
    check_eq("t4_rdata1", cap_rdata[1], 64'hA3);

    // saturation under continuous conflict, then clear
    for (int i = 0; i < 40; i++) begin
      set_idle();
      set_port(0, 1'b0, 0, 1'b0, 8'h00, 64'd0);
      set_port(1, 1'b0, 4, 1'b0, 8'h00, 64'd0);
      step();
    end
    #1;
    check_eq("t5_sat0", 64'(conflict_cnt_o[0]), 64'(CNT_MAX));
    check_eq("t5_sat1", 64'(conflict_cnt_o[1]), 64'(CNT_MAX));
    s_clr = 1'b1;
    step();
    #1;
    check_eq("t5_clr0", 64'(conflict_cnt_o[0]), 64'd0);
    check_eq("t5_clr1", 64'(conflict_cnt_o[1]), 64'd0);
    set_idle();
    step();

    // reset right after a grant: response is dropped, pointers restart at 0
    do_reset();
    set_idle();
    set_port(0, 1'b0, 0, 1'b0, 8'h00, 64'd0);
    set_port(1, 1'b0, 4, 1'b0, 8'h00, 64'd0);
    drive();
    #1;
    check_eq("t6_pre_gnt", 64'(gnt_o), 64'b01);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_dropped", 64'(rvalid_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    check_eq("t6_p0_wins", 64'(cap_gnt), 64'b01);
    set_idle();
    step();

    // random traffic; ungranted requests are held until accepted
    set_idle();
    m_gnt = '0;
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (m_gnt[p] || !s_req[p]) begin
          if ($urandom_range(3) != 0) begin
            int b, r, w;
            bit mode;
            mode = 1'($urandom_range(1));
            b = $urandom_range(NB - 1);
            r = $urandom_range(7);
            w = mode ? (b * BW + r) : (r * NB + b);
            set_port(p, mode, w, 1'($urandom_range(1)), BEW'($urandom), {$urandom, $urandom});
          end else begin
            s_req[p] = 1'b0;
          end
        end
      end
      s_clr = ($urandom_range(31) == 0);
      step();
    end
    set_idle();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
